// File: rtl/mips_io_pkg.sv
// Shared constants and helpers for the MIPS data-side IO bridge.
// Latency: none (declarations only).
// Backpressure: none.
package mips_io_pkg;

  // IO register word addresses (low byte of the byte address)
  localparam logic [7:0] IO_BASE     = 8'h80;
  localparam logic [7:0] SW_ADDR     = 8'h80;
  localparam logic [7:0] STATUS_ADDR = 8'h84;
  localparam logic [7:0] LED_ADDR    = 8'h88;
  localparam logic [7:0] SEG_ADDR    = 8'h8C;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// Load/store bus between the core's ALU/write-back path and the bridge.
// Latency: readdata combinational from addr; stores commit on the next clk edge.
// Backpressure: none; every access completes in its own cycle.
interface mem_io_bridge_if;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;

  modport master (output addr, output writedata, output memwrite, input readdata);
  modport slave  (input addr, input writedata, input memwrite, output readdata);
endinterface

// File: rtl/mem_io_bridge_scan.sv
// Multiplexed 8-digit seven-segment scanner for a 32-bit hex value.
// Latency: digit advances every 2^SCAN_BITS clocks; value changes show immediately.
// Backpressure: none; free-running.
module seg7_scan
  import mips_io_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  output logic [7:0]  an,
  output logic [6:0]  a2g
);

  localparam int CW = SCAN_BITS + 3;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx;
  logic [3:0]    nib;

  // Free-running counter wraps naturally from all-ones to zero
  always_comb begin
    cnt_d = cnt_q + CW'(1);
  end

  // Scan counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign idx = cnt_q[CW-1 -: 3];

  // Select the active digit's nibble and drive enables/segments
  always_comb begin
    nib = value[{idx, 2'b00} +: 4];
    an  = ~(8'd1 << idx);
    a2g = hex7seg(nib);
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Data-side port of the core: decodes addr into data RAM or IO registers.
// Latency: loads combinational; stores commit next edge; sw 2 clk, btn 3 clk.
// Backpressure: none; single-cycle access, no stall path.
module mem_io_bridge
  import mips_io_pkg::*;
#(
  parameter int RAM_WORDS = 32,
  parameter int SCAN_BITS = 17
) (
  input  logic             clk,
  input  logic             reset,
  mem_io_bridge_if.slave   bus,
  input  logic [15:0]      sw,
  input  logic             btn,
  output logic [15:0]      led,
  output logic [7:0]       an,
  output logic [6:0]       a2g
);

  logic [31:0] ram_q [RAM_WORDS];

  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sw_s1_q, sw_s2_q;
  logic        btn_s1_q, btn_s2_q, btn_prev_q;
  logic        pend_q, pend_d;

  logic        is_ram, is_io;
  logic [4:0]  ram_idx;
  logic [7:0]  io_word;
  logic        we_ram, we_led, we_seg, clr_pend, btn_rise;
  logic [31:0] rdata;
  logic        unused_addr_lsbs;

  assign is_ram   = (bus.addr[31:7] == 25'd0);
  assign is_io    = (bus.addr[31:8] == 24'd0) && bus.addr[7];
  assign ram_idx  = bus.addr[6:2];
  // Byte offset within a word is ignored for IO registers too
  assign io_word  = {bus.addr[7:2], 2'b00};
  assign unused_addr_lsbs = ^bus.addr[1:0];

  assign we_ram   = bus.memwrite && is_ram;
  assign we_led   = bus.memwrite && is_io && (io_word == LED_ADDR);
  assign we_seg   = bus.memwrite && is_io && (io_word == SEG_ADDR);
  assign clr_pend = bus.memwrite && is_io && (io_word == STATUS_ADDR) && bus.writedata[0];
  assign btn_rise = btn_s2_q && !btn_prev_q;

  // RAM write port; deliberately outside reset so a store in a reset cycle still lands
  always_ff @(posedge clk) begin
    if (we_ram) ram_q[ram_idx] <= bus.writedata;
  end

  // Next-state for the writable registers; a new button edge beats a clear
  always_comb begin
    led_d  = we_led ? bus.writedata[15:0] : led_q;
    seg_d  = we_seg ? bus.writedata       : seg_q;
    pend_d = pend_q;
    if (clr_pend) pend_d = 1'b0;
    if (btn_rise) pend_d = 1'b1;
  end

  // IO registers, synchronisers and edge-detect flop
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= '0;
      seg_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      led_q      <= led_d;
      seg_q      <= seg_d;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      pend_q     <= pend_d;
    end
  end

  // Load mux: RAM, mapped IO, or zero for anything unmapped
  always_comb begin
    rdata = 32'd0;
    if (is_ram) begin
      rdata = ram_q[ram_idx];
    end else if (is_io) begin
      case (io_word)
        SW_ADDR:     rdata = {16'd0, sw_s2_q};
        STATUS_ADDR: rdata = {31'd0, pend_q};
        LED_ADDR:    rdata = {16'd0, led_q};
        SEG_ADDR:    rdata = seg_q;
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign bus.readdata = rdata;
  assign led          = led_q;

  seg7_scan #(.SCAN_BITS(SCAN_BITS)) u_scan (
    .clk   (clk),
    .reset (reset),
    .value (seg_q),
    .an    (an),
    .a2g   (a2g)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a short scan period.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next edge.
// Backpressure: none.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  a2g;

  int n_cmp = 0;
  int n_bad = 0;

  // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  mem_io_bridge_if bus ();

  mem_io_bridge #(.RAM_WORDS(32), .SCAN_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .btn   (btn),
    .led   (led),
    .an    (an),
    .a2g   (a2g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr      = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    tick(1);
    bus.memwrite  = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr     = a;
    bus.memwrite = 1'b0;
    #1;
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    logic [31:0] segval;
    int          idx;

    reset         = 1'b1;
    bus.addr      = 32'd0;
    bus.writedata = 32'd0;
    bus.memwrite  = 1'b0;
    sw            = 16'd0;
    btn           = 1'b0;
    tick(3);

    check("rst_led", led, 32'h0);
    check("rst_an", an, 32'hFE);
    check("rst_a2g", a2g, 32'h40);
    check_rd("rst_seg_rd", 32'h8C, 32'h0);
    reset = 1'b0;
    tick(1);

    // RAM stores and loads
    store(32'h00, 32'hCAFEF00D);
    store(32'h10, 32'hDEADBEEF);
    store(32'h7C, 32'h12345678);
    check_rd("ram_10", 32'h10, 32'hDEADBEEF);
    check_rd("ram_7c", 32'h7C, 32'h12345678);
    check_rd("ram_7e_lsb_ignored", 32'h7E, 32'h12345678);
    tick(1);
    check_rd("unmapped_100", 32'h100, 32'h0);
    check_rd("unmapped_90", 32'h90, 32'h0);
    store(32'h100, 32'h55555555);
    check_rd("ram_00_after_100_store", 32'h00, 32'hCAFEF00D);
    tick(1);

    // Load in the storing cycle sees the old word
    bus.addr      = 32'h10;
    bus.writedata = 32'h11112222;
    bus.memwrite  = 1'b1;
    #1;
    check("ram_same_cycle_old", bus.readdata, 32'hDEADBEEF);
    tick(1);
    bus.memwrite = 1'b0;
    check_rd("ram_next_cycle_new", 32'h10, 32'h11112222);
    tick(1);

    // LED register
    store(32'h88, 32'h0000A5A5);
    check("led_after_store", led, 32'hA5A5);
    check_rd("led_rd", 32'h88, 32'h0000A5A5);
    tick(1);
    store(32'h80, 32'hFFFFFFFF);
    check_rd("sw_write_ignored", 32'h80, 32'h0);

    // Switch synchroniser: two clocks
    sw = 16'h1234;
    check_rd("sw_0clk", 32'h80, 32'h0);
    tick(1);
    check_rd("sw_1clk", 32'h80, 32'h0);
    tick(1);
    check_rd("sw_2clk", 32'h80, 32'h1234);
    tick(1);

    // Button latch
    check_rd("status_idle", 32'h84, 32'h0);
    btn = 1'b1;
    tick(1);
    check_rd("btn_1clk", 32'h84, 32'h0);
    tick(1);
    check_rd("btn_2clk", 32'h84, 32'h0);
    tick(1);
    check_rd("btn_3clk", 32'h84, 32'h1);
    tick(2);
    btn = 1'b0;
    tick(3);
    check_rd("btn_sticky", 32'h84, 32'h1);
    store(32'h84, 32'h2);
    check_rd("status_bit0_clear_only", 32'h84, 32'h1);
    tick(1);
    store(32'h84, 32'h1);
    check_rd("status_cleared", 32'h84, 32'h0);
    tick(1);
    btn = 1'b1;
    tick(2);
    store(32'h84, 32'h1);
    check_rd("set_beats_clear", 32'h84, 32'h1);
    btn = 1'b0;
    tick(4);
    store(32'h84, 32'h1);

    // Display scan from a known counter phase
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    segval = 32'h89ABCDEF;
    store(32'h8C, segval);
    for (int k = 1; k <= 33; k++) begin
      idx = (k >> 2) & 7;
      check($sformatf("scan_an_k%0d", k), an, ~(32'd1 << idx) & 32'hFF);
      check($sformatf("scan_a2g_k%0d", k), a2g, seg_tbl[(segval >> (idx * 4)) & 32'hF]);
      tick(1);
    end

    // Reset mid-scan drops LED store, RAM store still commits
    store(32'h88, 32'h0000FFFF);
    tick(5);
    check("led_ffff", led, 32'hFFFF);
    reset         = 1'b1;
    bus.addr      = 32'h88;
    bus.writedata = 32'h00001234;
    bus.memwrite  = 1'b1;
    tick(1);
    check("midrst_an", an, 32'hFE);
    check("midrst_led", led, 32'h0);
    check("midrst_a2g", a2g, 32'h40);
    bus.addr      = 32'h20;
    bus.writedata = 32'h0BADC0DE;
    tick(1);
    bus.memwrite = 1'b0;
    reset        = 1'b0;
    check_rd("ram_write_in_reset", 32'h20, 32'h0BADC0DE);
    tick(1);
    check("led_store_dropped", led, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
